// File: rtl/card_deal_sequencer.sv
// card_deal_sequencer: deals cards from a random source into player/dealer hands,
// keeps registered blackjack totals and resolves which card lies under a pixel.
module card_deal_sequencer #(
    parameter int MAX_CARDS = 6,
    parameter int CARD_W    = 60,
    parameter int CARD_H    = 84,
    parameter int PITCH     = 68,
    parameter int HAND_X0   = 40,
    parameter int DEALER_Y  = 60,
    parameter int PLAYER_Y  = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       deal_req,
    input  logic       deal_target,
    input  logic       new_round,
    input  logic       reveal_hole,
    output logic       rnd_req,
    input  logic       rnd_ack,
    input  logic [3:0] rnd_value,
    output logic       busy,
    output logic       deal_err,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic [9:0] card_x,
    output logic [8:0] card_y,
    output logic [3:0] card_value,
    output logic       card_visible,
    output logic [5:0] player_total,
    output logic [5:0] dealer_total,
    output logic [2:0] player_count,
    output logic [2:0] dealer_count,
    output logic       player_bust,
    output logic       dealer_bust
);
    typedef enum logic [1:0] {IDLE, REQ, STORE, UPDATE} state_t;
    localparam logic [2:0] FULL = 3'(MAX_CARDS);

    state_t state_q, state_d;
    logic tgt_q, tgt_d, rnd_req_q, rnd_req_d, deal_err_q, deal_err_d;
    logic [3:0] val_q, val_d;
    logic [MAX_CARDS-1:0][3:0] hand_q [2], hand_d [2];
    logic [2:0] count_q [2], count_d [2];
    logic [5:0] total_q [2], total_d [2], best [2];
    logic bust_q [2], bust_d [2];
    logic dealer_row, player_row;
    logic [8:0] row_y;

    function automatic logic [5:0] best_total(input logic [MAX_CARDS-1:0][3:0] cards, input logic [2:0] n);
        logic [5:0] hard;
        logic ace;
        hard = '0;
        ace  = 1'b0;
        for (int k = 0; k < MAX_CARDS; k++) begin
            if (k < int'(n)) begin
                hard = hard + (cards[k] > 4'd10 ? 6'd10 : {2'b00, cards[k]});
                ace  = ace | (cards[k] == 4'd1);
            end
        end
        return (ace && hard <= 6'd11) ? hard + 6'd10 : hard;
    endfunction

    assign best[0] = best_total(hand_q[0], count_q[0]);
    assign best[1] = best_total(hand_q[1], count_q[1]);

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        rnd_req_d  = rnd_req_q;
        deal_err_d = 1'b0;
        val_d      = val_q;
        hand_d     = hand_q;
        count_d    = count_q;
        total_d    = total_q;
        bust_d     = bust_q;
        if (new_round) begin
            state_d   = IDLE;
            rnd_req_d = 1'b0;
            count_d   = '{default: '0};
            total_d   = '{default: '0};
            bust_d    = '{default: 1'b0};
        end else begin
            case (state_q)
                IDLE: if (deal_req) begin
                    if (count_q[deal_target] < FULL) begin
                        state_d   = REQ;
                        tgt_d     = deal_target;
                        rnd_req_d = 1'b1;
                    end else deal_err_d = 1'b1;
                end
                // an invalid code drops rnd_req for one cycle before retrying
                REQ: if (rnd_req_q && rnd_ack) begin
                    rnd_req_d = 1'b0;
                    val_d     = rnd_value;
                    if (rnd_value != 4'd0 && rnd_value <= 4'd13) state_d = STORE;
                end else rnd_req_d = 1'b1;
                STORE: begin
                    hand_d[tgt_q][count_q[tgt_q]] = val_q;
                    count_d[tgt_q] = count_q[tgt_q] + 3'd1;
                    state_d = UPDATE;
                end
                default: begin
                    total_d   = best;
                    bust_d[0] = best[0] > 6'd21;
                    bust_d[1] = best[1] > 6'd21;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tgt_q      <= 1'b0;
            rnd_req_q  <= 1'b0;
            deal_err_q <= 1'b0;
            val_q      <= '0;
            hand_q     <= '{default: '0};
            count_q    <= '{default: '0};
            total_q    <= '{default: '0};
            bust_q     <= '{default: 1'b0};
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            rnd_req_q  <= rnd_req_d;
            deal_err_q <= deal_err_d;
            val_q      <= val_d;
            hand_q     <= hand_d;
            count_q    <= count_d;
            total_q    <= total_d;
            bust_q     <= bust_d;
        end
    end

    assign rnd_req      = rnd_req_q;
    assign busy         = state_q != IDLE;
    assign deal_err     = deal_err_q;
    assign player_count = count_q[0];
    assign dealer_count = count_q[1];
    assign player_total = total_q[0];
    assign dealer_total = total_q[1];
    assign player_bust  = bust_q[0];
    assign dealer_bust  = bust_q[1];

    assign dealer_row = int'(y) >= DEALER_Y && int'(y) < DEALER_Y + CARD_H;
    assign player_row = int'(y) >= PLAYER_Y && int'(y) < PLAYER_Y + CARD_H;
    assign row_y      = 9'(dealer_row ? DEALER_Y : PLAYER_Y);

    always_comb begin
        card_x       = '0;
        card_y       = '0;
        card_value   = '0;
        card_visible = 1'b0;
        for (int k = 0; k < MAX_CARDS; k++) begin
            if ((dealer_row || player_row) && k < int'(count_q[dealer_row]) &&
                int'(x) >= HAND_X0 + k * PITCH && int'(x) < HAND_X0 + k * PITCH + CARD_W) begin
                card_x       = 10'(HAND_X0 + k * PITCH);
                card_y       = row_y;
                card_value   = hand_q[dealer_row][k];
                card_visible = !(dealer_row && k == 1 && !reveal_hole);
            end
        end
    end
endmodule

// File: tb/tb_card_deal_sequencer.sv
// tb_card_deal_sequencer: transaction-level hand model with per-cycle compare,
// directed deal scenarios and randomized traffic.
module tb_card_deal_sequencer;
    logic       clk = 0, reset = 1, deal_req = 0, deal_target = 0, new_round = 0;
    logic       reveal_hole = 0, rnd_ack = 0;
    logic [3:0] rnd_value = 0;
    logic [9:0] x = 0;
    logic [8:0] y = 0;
    logic       rnd_req, busy, deal_err, card_visible, player_bust, dealer_bust;
    logic [9:0] card_x;
    logic [8:0] card_y;
    logic [3:0] card_value;
    logic [5:0] player_total, dealer_total;
    logic [2:0] player_count, dealer_count;

    card_deal_sequencer dut (
        .clk(clk), .reset(reset), .deal_req(deal_req), .deal_target(deal_target),
        .new_round(new_round), .reveal_hole(reveal_hole), .rnd_req(rnd_req),
        .rnd_ack(rnd_ack), .rnd_value(rnd_value), .busy(busy), .deal_err(deal_err),
        .x(x), .y(y), .card_x(card_x), .card_y(card_y), .card_value(card_value),
        .card_visible(card_visible), .player_total(player_total), .dealer_total(dealer_total),
        .player_count(player_count), .dealer_count(dealer_count),
        .player_bust(player_bust), .dealer_bust(dealer_bust)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    bit en = 0;
    int ph[$], dh[$];
    bit m_wait = 0, m_req = 0, m_err = 0, mb_p = 0, mb_d = 0;
    int m_pend = 0, m_tgt = 0, m_card = 0, mt_p = 0, mt_d = 0;
    int h_m, k_m, off_m, ex_x, ex_y, ex_v, ex_vis, sz;

    function automatic int best_of(input int q[$]);
        int s = 0;
        bit a = 0;
        foreach (q[i]) begin
            s += (q[i] > 10) ? 10 : q[i];
            if (q[i] == 1) a = 1;
        end
        return (a && s <= 11) ? s + 10 : s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
        end
    endtask

    // reference model: advances one clock at a time on the inputs alone
    initial forever begin
        @(posedge clk);
        if (reset || new_round) begin
            ph.delete(); dh.delete();
            m_wait = 0; m_req = 0; m_pend = 0; m_err = 0;
            mt_p = 0; mt_d = 0; mb_p = 0; mb_d = 0;
        end else begin
            m_err = 0;
            if (m_pend == 2) begin
                if (m_tgt == 1) dh.push_back(m_card); else ph.push_back(m_card);
                m_pend = 1;
            end else if (m_pend == 1) begin
                mt_p = best_of(ph); mt_d = best_of(dh);
                mb_p = mt_p > 21; mb_d = mt_d > 21;
                m_pend = 0;
            end else if (m_wait) begin
                if (m_req && rnd_ack) begin
                    m_req = 0;
                    if (rnd_value >= 1 && rnd_value <= 13) begin
                        m_wait = 0; m_card = int'(rnd_value); m_pend = 2;
                    end
                end else m_req = 1;
            end else if (deal_req) begin
                if ((deal_target ? dh.size() : ph.size()) < 6) begin
                    m_wait = 1; m_req = 1; m_tgt = int'(deal_target);
                end else m_err = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (en) begin
            chk("busy", busy, m_wait || m_pend != 0);
            chk("rnd_req", rnd_req, m_req);
            chk("deal_err", deal_err, m_err);
            chk("player_count", player_count, ph.size());
            chk("dealer_count", dealer_count, dh.size());
            chk("player_total", player_total, mt_p);
            chk("dealer_total", dealer_total, mt_d);
            chk("player_bust", player_bust, mb_p);
            chk("dealer_bust", dealer_bust, mb_d);
            ex_x = 0; ex_y = 0; ex_v = 0; ex_vis = 0; h_m = -1;
            if (y >= 60 && y < 144) h_m = 1;
            else if (y >= 300 && y < 384) h_m = 0;
            if (h_m >= 0 && x >= 40) begin
                k_m = (int'(x) - 40) / 68;
                off_m = (int'(x) - 40) % 68;
                sz = (h_m == 1) ? dh.size() : ph.size();
                if (off_m < 60 && k_m < sz) begin
                    ex_x = 40 + 68 * k_m;
                    ex_y = (h_m == 1) ? 60 : 300;
                    ex_v = (h_m == 1) ? dh[k_m] : ph[k_m];
                    ex_vis = !(h_m == 1 && k_m == 1 && !reveal_hole);
                end
            end
            chk("card_x", card_x, ex_x);
            chk("card_y", card_y, ex_y);
            chk("card_value", card_value, ex_v);
            chk("card_visible", card_visible, ex_vis);
        end
    end

    task automatic deal(input logic t, input logic [3:0] v);
        int n;
        n = 0;
        deal_req = 1; deal_target = t;
        @(negedge clk);
        deal_req = 0;
        while (!rnd_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("deal_rnd_req", rnd_req, 1);
        rnd_ack = 1; rnd_value = v;
        @(negedge clk);
        rnd_ack = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic nr();
        new_round = 1;
        @(negedge clk);
        new_round = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 0; en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_pcount", player_count, 0);
        chk("rst_rnd_req", rnd_req, 0);
        chk("rst_ptotal", player_total, 0);
        deal(0, 1); deal(0, 13);
        chk("ace_king_count", player_count, 2);
        chk("ace_king_total", player_total, 21);
        chk("ace_king_bust", player_bust, 0);
        chk("ace_king_busy", busy, 0);
        nr();
        deal(0, 10); deal(0, 10); deal(0, 5);
        chk("bust_total", player_total, 25);
        chk("bust_flag", player_bust, 1);
        deal(0, 3);
        chk("fourth_count", player_count, 4);
        chk("fourth_total", player_total, 28);
        deal(0, 2); deal(0, 4);
        chk("full_count", player_count, 6);
        deal_req = 1; deal_target = 0;
        @(negedge clk);
        deal_req = 0;
        chk("full_err_hi", deal_err, 1);
        chk("full_rnd_req", rnd_req, 0);
        @(negedge clk);
        chk("full_err_lo", deal_err, 0);
        chk("full_count_kept", player_count, 6);
        chk("full_busy", busy, 0);
        nr();
        deal_req = 1; deal_target = 0;
        @(negedge clk);
        deal_req = 0;
        chk("bad_req_on", rnd_req, 1);
        rnd_ack = 1; rnd_value = 14;
        @(negedge clk);
        rnd_ack = 0;
        chk("bad_req_drop", rnd_req, 0);
        chk("bad_busy", busy, 1);
        @(negedge clk);
        chk("bad_req_again", rnd_req, 1);
        rnd_ack = 1; rnd_value = 7;
        @(negedge clk);
        rnd_ack = 0;
        @(negedge clk);
        @(negedge clk);
        chk("retry_count", player_count, 1);
        chk("retry_total", player_total, 7);
        x = 50; y = 310;
        #1;
        chk("retry_value", card_value, 7);
        chk("retry_vis", card_visible, 1);
        @(negedge clk);
        nr();
        deal(1, 5); deal(1, 9);
        chk("dealer_total_14", dealer_total, 14);
        x = 120; y = 100; reveal_hole = 0;
        #1;
        chk("hole_x", card_x, 108);
        chk("hole_y", card_y, 60);
        chk("hole_hidden", card_visible, 0);
        reveal_hole = 1;
        #1;
        chk("hole_shown", card_visible, 1);
        chk("hole_value", card_value, 9);
        x = 104;
        #1;
        chk("gap_x", card_x, 0);
        chk("gap_y", card_y, 0);
        chk("gap_value", card_value, 0);
        chk("gap_vis", card_visible, 0);
        @(negedge clk);
        nr();
        deal(0, 4);
        deal_req = 1; deal_target = 0;
        @(negedge clk);
        deal_req = 0;
        chk("abort_req_on", rnd_req, 1);
        new_round = 1;
        @(negedge clk);
        new_round = 0;
        chk("abort_req_off", rnd_req, 0);
        chk("abort_count", player_count, 0);
        chk("abort_busy", busy, 0);
        rnd_ack = 1; rnd_value = 5;
        @(negedge clk);
        rnd_ack = 0;
        @(negedge clk);
        @(negedge clk);
        chk("late_ack_count", player_count, 0);
        chk("late_ack_busy", busy, 0);
        reveal_hole = 0;
        repeat (4000) begin
            @(negedge clk);
            reset = $urandom_range(0, 299) == 0;
            new_round = $urandom_range(0, 59) == 0;
            deal_req = $urandom_range(0, 2) == 0;
            deal_target = 1'($urandom_range(0, 1));
            rnd_ack = $urandom_range(0, 4) < 2;
            rnd_value = 4'($urandom_range(0, 15));
            x = 10'($urandom_range(0, 520));
            y = 9'($urandom_range(0, 1) == 1 ? $urandom_range(50, 150) : $urandom_range(290, 390));
            if ($urandom_range(0, 49) == 0) reveal_hole = ~reveal_hole;
        end
        @(negedge clk);
        reset = 0; new_round = 0; deal_req = 0; rnd_ack = 0;
        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
